// File: rtl/if_id_skid.sv
// if_id_skid -- two-entry skid buffer between the fetch (IF) and decode (ID)
// stages of an RV64I pipeline.
//
// Entries are delivered in acceptance order. A new entry appears on out_* no
// earlier than the cycle after it is accepted. With out_ready held high the
// buffer passes one entry per cycle with no bubbles.
//
// Ports
//   clk         clock
//   rst         synchronous, active-high reset; wins over flush and handshakes
//   in_valid    fetch presents a valid pc/inst pair
//   in_pc       pc of the fetched instruction (64 bits)
//   in_inst     fetched instruction word (32 bits)
//   in_ready    buffer accepts the pair this cycle (decoded from state only)
//   flush       redirect taken: discard held and incoming entries
//   out_valid   head entry valid
//   out_pc      pc of the head entry
//   out_inst    instruction word of the head entry
//   out_ready   decode consumes the head this cycle
//   out_illegal head instruction is not a 32-bit encoding (inst[1:0] != 2'b11)
//   stall_cnt   saturating count of cycles with a valid head held back
module if_id_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [63:0] in_pc,
  input  logic [31:0] in_inst,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        out_ready,
  output logic        out_illegal,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [63:0] RST_PC   = 64'h0;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

  // Anything whose low two bits are not 2'b11 is a compressed or invalid
  // encoding, which RV64I without C cannot execute.
  function automatic logic is_illegal(input logic [31:0] inst);
    return (inst[1:0] != 2'b11);
  endfunction

  state_t      state_r;
  logic [63:0] main_pc_r;
  logic [31:0] main_inst_r;
  logic        main_ill_r;
  logic [63:0] skid_pc_r;
  logic [31:0] skid_inst_r;
  logic        skid_ill_r;
  logic [31:0] stall_cnt_r;

  logic        in_fire_s;
  logic        out_fire_s;

  // Handshake status is decoded from the registered state only, so there is
  // no combinational path from out_ready or in_valid to in_ready.
  assign in_ready   = (state_r != TWO);
  assign out_valid  = (state_r != EMPTY);
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;

  // The head always comes from the main entry. The illegal flag is computed
  // when an entry is loaded, so the output is taken straight from a register.
  assign out_pc      = main_pc_r;
  assign out_inst    = main_inst_r;
  assign out_illegal = main_ill_r;
  assign stall_cnt   = stall_cnt_r;

  // Occupancy FSM and entry storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      main_pc_r   <= RST_PC;
      main_inst_r <= NOP_INST;
      main_ill_r  <= 1'b0;
      skid_pc_r   <= RST_PC;
      skid_inst_r <= NOP_INST;
      skid_ill_r  <= 1'b0;
    end else if (flush) begin
      // An out_fire in this cycle already counts as consumed by decode;
      // everything held or arriving is dropped.
      state_r <= EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            main_pc_r   <= in_pc;
            main_inst_r <= in_inst;
            main_ill_r  <= is_illegal(in_inst);
            state_r     <= ONE;
          end
        end
        ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_pc_r   <= in_pc;
            main_inst_r <= in_inst;
            main_ill_r  <= is_illegal(in_inst);
          end else if (in_fire_s) begin
            // Head is held, so park the newcomer behind it.
            skid_pc_r   <= in_pc;
            skid_inst_r <= in_inst;
            skid_ill_r  <= is_illegal(in_inst);
            state_r     <= TWO;
          end else if (out_fire_s) begin
            state_r <= EMPTY;
          end
        end
        TWO: begin
          if (out_fire_s) begin
            main_pc_r   <= skid_pc_r;
            main_inst_r <= skid_inst_r;
            main_ill_r  <= skid_ill_r;
            state_r     <= ONE;
          end
        end
        default: begin
          state_r <= EMPTY;
        end
      endcase
    end
  end

  // Saturating count of cycles in which decode holds a valid head back.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

endmodule

// File: doc/if_id_skid.md
IF_ID_SKID -- requirements
Module: if_id_skid

Interface
REQ-001 SHALL have ports, clock and reset first: clk input 1 clock; rst input 1 reset, synchronous, active-high.
REQ-002 SHALL have in_valid input 1: fetch stage presents a valid pc/inst pair.
REQ-003 SHALL have in_pc input 64: pc of fetched instruction.
REQ-004 SHALL have in_inst input 32: fetched instruction word.
REQ-005 SHALL have in_ready output 1: block accepts the pair this cycle.
REQ-006 SHALL have flush input 1: redirect taken (pcSrc); discard all held and incoming entries.
REQ-007 SHALL have out_valid output 1: decode-side entry valid.
REQ-008 SHALL have out_pc output 64, out_inst output 32: head entry to decode stage.
REQ-009 SHALL have out_ready input 1: decode stage consumes head this cycle.
REQ-010 SHALL have out_illegal output 1: head entry has out_inst[1:0] != 2'b11 (compressed/illegal for RV64I).
REQ-011 SHALL have stall_cnt output 32: perf counter of backpressured cycles.

Function
REQ-012 SHALL define in_fire = in_valid & in_ready, out_fire = out_valid & out_ready.
REQ-013 SHALL hold two entries, main and skid, under a 3-state FSM: EMPTY, ONE, TWO.
REQ-014 SHALL drive out_valid = (state != EMPTY); out_pc/out_inst/out_illegal from main entry only.
REQ-015 SHALL drive in_ready = (state != TWO), from registered state only; no combinational path from out_ready or in_valid.
REQ-016 EMPTY: in_fire -> load main, go ONE; else stay.
REQ-017 ONE: in_fire & out_fire -> load main with input, stay ONE; in_fire & !out_fire -> load skid, go TWO; !in_fire & out_fire -> EMPTY; neither -> stay.
REQ-018 TWO: out_fire -> main <= skid, go ONE; else stay; no input accepted.
REQ-019 SHALL deliver entries strictly in acceptance order; no entry duplicated or dropped absent flush.
REQ-020 Latency: entry accepted in cycle N SHALL appear on out_* in cycle N+1 at earliest; zero-bubble throughput of 1 entry/cycle when out_ready held high.
REQ-021 Head data SHALL remain stable while out_valid & !out_ready.
REQ-022 flush SHALL force next state EMPTY regardless of state, in_valid, out_ready; input presented that cycle is discarded.
REQ-023 out_fire in a flush cycle SHALL still count as consumed by decode; block takes no further action on it.
REQ-024 Data registers of invalid entries are don't-care except after reset (REQ-027).
REQ-025 stall_cnt SHALL increment by 1 on each cycle with out_valid & !out_ready & !flush; saturate at 32'hFFFF_FFFF; unaffected by flush otherwise.

Reset
REQ-026 rst SHALL take priority over flush and all handshakes.
REQ-027 On rst: state EMPTY, out_valid 0, in_ready 1, main/skid pc 64'h0, inst 32'h0000_0013 (nop), out_illegal 0, stall_cnt 0.
REQ-028 rst asserted mid-operation SHALL discard both entries; first post-reset accepted entry emerges as head.

Verification
REQ-029 Streaming: in_valid=1 pcs 0x8000_0000,+4,+8, out_ready=1 -> outputs same pcs on consecutive cycles from cycle 1, stall_cnt stays 0.
REQ-030 Backpressure: out_ready=0, push 0x8000_0000 then 0x8000_0004 -> in_ready=0 after second accept, out_pc holds 0x8000_0000, stall_cnt counts 1 per held cycle; release out_ready -> 0x8000_0000 then 0x8000_0004, in_ready back to 1.
REQ-031 Flush in TWO: two entries held, flush=1 with in_valid=1 pc 0x8000_0100 -> next cycle out_valid=0, in_ready=1; 0x8000_0100 never appears.
REQ-032 Simultaneous in/out in ONE: head 0x8000_0000, in 0x8000_0004, out_ready=1 -> next cycle state ONE, out_pc 0x8000_0004.
REQ-033 Illegal flag: in_inst 0x0000_4501 accepted -> out_illegal=1; 0x0000_0013 -> out_illegal=0.
REQ-034 Reset mid-TWO with flush=1 also high -> next cycle out_valid=0, out_inst 0x0000_0013, stall_cnt 0.
